// File: rtl/md_stall_ctrl_pkg.sv
// Shared MD-unit constants and shadow-state encoding.
// The MD unit and the stall controller both use these latencies.
package md_stall_ctrl_pkg;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_shadow_cnt.sv
// Load/decrement latency counter; done is high while cnt==1.
// Ports: clk, reset (sync, active-low), load, load_val -> cnt, done.
module md_shadow_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/md_stall_ctrl.sv
// D/E-boundary stall control shadowing the MD unit busy window.
// Ports: clk, reset, d_md_use, e_start, e_is_div, md_busy -> stall,
//   md_state, busy_exp, mismatch, restart_err, stall_cnt.
module md_stall_ctrl #(
  parameter int MULT_CYC = md_stall_ctrl_pkg::MULT_CYC,
  parameter int DIV_CYC  = md_stall_ctrl_pkg::DIV_CYC,
  parameter int CNT_W    = md_stall_ctrl_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md_use,
  input  logic        e_start,
  input  logic        e_is_div,
  input  logic        md_busy,
  output logic        stall,
  output logic [1:0]  md_state,
  output logic        busy_exp,
  output logic        mismatch,
  output logic        restart_err,
  output logic [31:0] stall_cnt
);
  import md_stall_ctrl_pkg::*;

  md_state_t        state_q;
  md_state_t        state_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             done;

  md_shadow_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A start while busy is ignored here, as the MD unit ignores it.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    unique case (state_q)
      MD_IDLE: begin
        if (e_start) begin
          load = 1'b1;
          if (e_is_div) begin
            state_d  = MD_DIV;
            load_val = CNT_W'(DIV_CYC);
          end else begin
            state_d  = MD_MULT;
            load_val = CNT_W'(MULT_CYC);
          end
        end
      end
      MD_MULT, MD_DIV: begin
        if (done) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign md_state = state_q;
  assign busy_exp = (state_q != MD_IDLE);
  assign stall    = d_md_use & (e_start | busy_exp);

  always_ff @(posedge clk) begin
    if (!reset) begin
      mismatch    <= 1'b0;
      restart_err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (md_busy != busy_exp) mismatch <= 1'b1;
      if (e_start && busy_exp) restart_err <= 1'b1;
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Random + directed bench for md_stall_ctrl against a cycle-window model.
// Model: a start in cycle c makes cycles c+1..c+N busy.
module tb_md_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        d_md_use;
  logic        e_start;
  logic        e_is_div;
  logic        md_busy;
  logic        stall;
  logic [1:0]  md_state;
  logic        busy_exp;
  logic        mismatch;
  logic        restart_err;
  logic [31:0] stall_cnt;

  md_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .d_md_use    (d_md_use),
    .e_start     (e_start),
    .e_is_div    (e_is_div),
    .md_busy     (md_busy),
    .stall       (stall),
    .md_state    (md_state),
    .busy_exp    (busy_exp),
    .mismatch    (mismatch),
    .restart_err (restart_err),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          busy_end = -1;
  logic [1:0]  kind = 2'd0;
  logic        m_mis = 1'b0;
  logic        m_rerr = 1'b0;
  logic [31:0] m_scnt = 32'd0;
  bit          started = 1'b0;
  bit          mb;

  function automatic bit m_busy();
    return cyc <= busy_end;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      started  = 1'b1;
      busy_end = -1;
      m_mis    = 1'b0;
      m_rerr   = 1'b0;
      m_scnt   = 32'd0;
    end else begin
      mb = m_busy();
      if (md_busy !== mb) m_mis = 1'b1;
      if (d_md_use && (e_start || mb) && m_scnt != 32'hFFFF_FFFF)
        m_scnt = m_scnt + 32'd1;
      if (e_start) begin
        if (mb) begin
          m_rerr = 1'b1;
        end else begin
          kind     = e_is_div ? 2'd2 : 2'd1;
          busy_end = cyc + (e_is_div ? DIV_N : MULT_N);
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, got, exp, $time);
    end
  endtask

  // bsel: 0/1 literal busy, 2 follow model, 3 follow with rare flip
  task automatic step(input logic r, input logic du,
                      input logic es, input logic isd,
                      input int bsel);
    bit eb;
    @(posedge clk);
    #2;
    reset    = r;
    d_md_use = du;
    e_start  = es;
    e_is_div = isd;
    case (bsel)
      0: md_busy = 1'b0;
      1: md_busy = 1'b1;
      2: md_busy = m_busy();
      default: md_busy = m_busy() ^ ($urandom_range(49) == 0);
    endcase
    @(negedge clk);
    if (started) begin
      eb = m_busy();
      check("stall", {31'd0, stall}, {31'd0, du & (es | eb)});
      check("md_state", {30'd0, md_state}, {30'd0, eb ? kind : 2'd0});
      check("busy_exp", {31'd0, busy_exp}, {31'd0, eb});
      check("mismatch", {31'd0, mismatch}, {31'd0, m_mis});
      check("restart_err", {31'd0, restart_err}, {31'd0, m_rerr});
      check("stall_cnt", stall_cnt, m_scnt);
    end
  endtask

  initial begin
    reset = 1'b0; d_md_use = 1'b0; e_start = 1'b0;
    e_is_div = 1'b0; md_busy = 1'b0;

    // reset for two cycles, stall combinational during reset
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    check("t1_state", {30'd0, md_state}, 32'd0);
    check("t1_scnt", stall_cnt, 32'd0);
    check("t1_mis", {31'd0, mismatch}, 32'd0);
    check("t1_stall", {31'd0, stall}, 32'd1);

    // mult: stall cycles 0..5
    step(1, 1, 1, 0, 2);
    check("t2_stall0", {31'd0, stall}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step(1, 1, 0, 0, 2);
      check("t2_state", {30'd0, md_state}, 32'd1);
      check("t2_stall", {31'd0, stall}, 32'd1);
    end
    step(1, 1, 0, 0, 2);
    check("t2_stall6", {31'd0, stall}, 32'd0);
    check("t2_idle", {30'd0, md_state}, 32'd0);
    check("t2_scnt", stall_cnt, 32'd6);
    check("t2_mis", {31'd0, mismatch}, 32'd0);

    // div: busy cycles 1..10, consumer issues at 11
    step(1, 0, 1, 1, 2);
    for (int i = 1; i <= 10; i++) begin
      step(1, 1, 0, 0, 2);
      check("t3_state", {30'd0, md_state}, 32'd2);
      check("t3_stall", {31'd0, stall}, 32'd1);
    end
    step(1, 1, 0, 0, 2);
    check("t3_idle", {30'd0, md_state}, 32'd0);
    check("t3_issue", {31'd0, stall}, 32'd0);

    // early busy drop -> sticky mismatch
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 2);
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 2);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 2);
    check("t4_mis5", {31'd0, mismatch}, 32'd1);
    for (int i = 6; i <= 10; i++) step(1, 0, 0, 0, 2);
    check("t4_mis_hold", {31'd0, mismatch}, 32'd1);
    check("t4_idle", {31'd0, busy_exp}, 32'd0);

    // restart during div
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 2);
    step(1, 0, 0, 0, 2);
    step(1, 0, 0, 0, 2);
    step(1, 0, 1, 0, 2);
    for (int i = 4; i <= 10; i++) begin
      step(1, 0, 0, 0, 2);
      check("t5_rerr", {31'd0, restart_err}, 32'd1);
      check("t5_state", {30'd0, md_state}, 32'd2);
    end
    step(1, 0, 0, 0, 2);
    check("t5_idle", {30'd0, md_state}, 32'd0);

    // reset mid-div, then a full mult
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 2);
    step(1, 1, 0, 0, 2);
    step(0, 1, 1, 0, 2);
    step(1, 0, 0, 0, 2);
    check("t6_state", {30'd0, md_state}, 32'd0);
    check("t6_bexp", {31'd0, busy_exp}, 32'd0);
    check("t6_rerr", {31'd0, restart_err}, 32'd0);
    check("t6_scnt", stall_cnt, 32'd0);
    step(1, 0, 1, 0, 2);
    for (int i = 5; i <= 9; i++) begin
      step(1, 0, 0, 0, 2);
      check("t6_mult", {30'd0, md_state}, 32'd1);
    end
    step(1, 0, 0, 0, 2);
    check("t6_done", {30'd0, md_state}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) != 0,
           $urandom_range(1),
           $urandom_range(5) == 0,
           $urandom_range(1),
           3);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
